burst_sram_responder: RTL and testbench
=======================================

# burst_sram_responder

Responder end of the burst RAM command interface driven by `cache`: accepts read/write burst commands on the `cmd`/`cmd_en`/`addr` port and services them against a plain single-port synchronous SRAM with 64-bit words and byte write enables. It gives simulation and FPGA builds a drop-in burst target with the same handshake and timing as the PSRAM path, backed by block RAM. It owns the init delay, burst sequencing, read latency shaping and data-mask handling.

## Interface
- `AddressBitWidth`, 10, width of `addr` and `sram_addr`; 64-bit word address space of 2^AddressBitWidth words
- `BurstDataCount`, 4, 64-bit beats per burst; power of two, 2..8
- `CyclesBeforeDataValid`, 6, cycles from accepted read `cmd_en` to first `rd_data_valid`; legal 2..31
- `InitCycles`, 8, cycles after reset release before `init_calib` rises; legal 1..255
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `cmd` in 1: 0 read, 1 write; sampled with `cmd_en`
- `cmd_en` in 1: command and `addr` valid this cycle
- `addr` in AddressBitWidth: start word address of burst
- `wr_data` in 64: write beat data
- `data_mask` in 8: per-byte mask, 1 = byte not written; applies to every beat of the burst, sampled per beat
- `rd_data` out 64: read beat data
- `rd_data_valid` out 1: `rd_data` valid this cycle
- `init_calib` out 1: responder ready after init
- `busy` out 1: command not accepted this cycle
- `sram_addr` out AddressBitWidth: SRAM word address
- `sram_wr_data` out 64: SRAM write data
- `sram_we` out 8: SRAM byte write enables
- `sram_rd_data` in 64: SRAM read data, valid one cycle after address presented

## Operation
- States: INIT, IDLE, WRITE, READ_WAIT, READ_BURST.
- INIT: counter runs InitCycles cycles after `rst` falls; then `init_calib`=1 (sticky until reset), go IDLE.
- IDLE: `busy`=0. Command accepted on edge where `cmd_en`=1 and `busy`=0. `cmd_en` while `busy`=1 is ignored, no queuing.
- Write: beat 0 = `wr_data` on the accept cycle; beats 1..N-1 on the following N-1 consecutive cycles (N = BurstDataCount). Beat i written to word `addr`+i; `sram_we` = ~`data_mask` registered with the beat.
- Read: beat i from word `addr`+i, returned in order on consecutive cycles.
- Address arithmetic: beat address = (`addr` + i) mod 2^AddressBitWidth; a burst at the top of memory wraps to word 0. No alignment required.
- `rd_data` holds the last beat when `rd_data_valid`=0.
- Reset mid-burst: all state cleared immediately; partially written burst leaves already-written beats in SRAM; no `rd_data_valid` after reset until a new read.

## Timing
- Reset values: `busy`=1, `init_calib`=0, `rd_data_valid`=0, `rd_data`=0, `sram_we`=0, `sram_addr`=0, `sram_wr_data`=0.
- `init_calib` rises at edge InitCycles after `rst` deasserts; `busy` falls on the same edge.
- Accept at edge T. `busy`=1 from T through the last beat cycle; `busy`=0 again in the cycle after the last beat, so next command accepted earliest one cycle after burst end.
- Write: beats captured at edges T..T+N-1; SRAM writes at edges T+1..T+N; `busy` falls at edge T+N.
- Read: SRAM addresses presented from edge T+CyclesBeforeDataValid-2; `rd_data_valid`=1 for cycles following edges T+C..T+C+N-1 (C = CyclesBeforeDataValid), exactly N cycles, no gaps; `busy` falls at edge T+C+N.
- A write beat and a later read of the same word never overlap: read accept only after write `busy` clears.

## Test plan
- Init: release `rst`, InitCycles=8 -> `init_calib`=0 and `busy`=1 for 8 cycles, then `init_calib`=1, `busy`=0; all other outputs 0 throughout.
- Write/read: write burst at addr 0x10, beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., mask 0 -> read at 0x10 returns same four beats, `rd_data_valid` first asserted exactly 6 cycles after accept, high 4 cycles.
- Byte mask: preload word 0x20 = 0xFFFF_FFFF_FFFF_FFFF, write 0 with `data_mask`=8'h0F -> readback 0x0000_0000_FFFF_FFFF.
- Wrap: write burst at addr 0x3FE with beats A,B,C,D -> words 0x3FE,0x3FF,0x000,0x001 hold A,B,C,D; read at 0x3FE returns A,B,C,D.
- Busy discipline: `cmd_en` asserted during an active read burst with write of 0xDEAD -> ignored, memory unchanged, read beats unaffected; back-to-back command in first `busy`=0 cycle accepted.
- Reset mid-read: assert `rst` during READ_WAIT -> `rd_data_valid` stays 0, `busy`=1, `init_calib`=0 immediately; after re-init, earlier data still readable.

Source files
------------

// File: rtl/burst_sram_responder.sv
// Burst command responder backed by a single-port synchronous SRAM with byte enables.
// Sequences N-beat read/write bursts, shapes read latency and holds off commands while busy.
module burst_sram_responder #(
   parameter int AddressBitWidth       = 10,
   parameter int BurstDataCount        = 4,
   parameter int CyclesBeforeDataValid = 6,
   parameter int InitCycles            = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd,
   input  logic                       cmd_en,
   input  logic [AddressBitWidth-1:0] addr,
   input  logic [63:0]                wr_data,
   input  logic [7:0]                 data_mask,
   output logic [63:0]                rd_data,
   output logic                       rd_data_valid,
   output logic                       init_calib,
   output logic                       busy,
   output logic [AddressBitWidth-1:0] sram_addr,
   output logic [63:0]                sram_wr_data,
   output logic [7:0]                 sram_we,
   input  logic [63:0]                sram_rd_data
);

   typedef enum logic [2:0] {INIT, IDLE, WRITE, READ_WAIT, READ_BURST} state_t;

   localparam logic [7:0] InitLast  = 8'(InitCycles - 1);
   localparam logic [7:0] BurstLen  = 8'(BurstDataCount);
   localparam logic [7:0] AddrFirst = 8'(CyclesBeforeDataValid - 2);
   localparam logic [7:0] DataFirst = 8'(CyclesBeforeDataValid);
   localparam logic [7:0] DataStop  = 8'(CyclesBeforeDataValid + BurstDataCount);
   localparam logic [AddressBitWidth-1:0] AddrOne = {{(AddressBitWidth-1){1'b0}}, 1'b1};

   state_t                     r_state;
   logic [7:0]                 r_cnt;
   logic [AddressBitWidth-1:0] r_nextAddr;
   logic [AddressBitWidth-1:0] r_sramAddr;
   logic [63:0]                r_sramWrData;
   logic [7:0]                 r_sramWe;
   logic [63:0]                r_rdData;
   logic                       r_rdValid;
   logic                       r_initCalib;
   logic                       r_busy;

   logic [7:0] w_addrOffset;
   logic [7:0] w_dataOffset;
   logic       w_addrIssue;
   logic       w_dataCapture;

   // r_cnt counts edges since the accept edge; offsets wrap so "in window" is one compare
   assign w_addrOffset  = r_cnt - AddrFirst;
   assign w_dataOffset  = r_cnt - DataFirst;
   assign w_addrIssue   = (w_addrOffset < BurstLen);
   assign w_dataCapture = (w_dataOffset < BurstLen);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= INIT;
         r_cnt        <= 8'd0;
         r_nextAddr   <= '0;
         r_sramAddr   <= '0;
         r_sramWrData <= 64'd0;
         r_sramWe     <= 8'd0;
         r_rdData     <= 64'd0;
         r_rdValid    <= 1'b0;
         r_initCalib  <= 1'b0;
         r_busy       <= 1'b1;
      end else begin
         case (r_state)
            INIT: begin
               if (r_cnt == InitLast) begin
                  r_initCalib <= 1'b1;
                  r_busy      <= 1'b0;
                  r_cnt       <= 8'd0;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            IDLE: begin
               if (cmd_en) begin
                  r_busy <= 1'b1;
                  r_cnt  <= 8'd1;
                  if (cmd) begin
                     r_sramAddr   <= addr;
                     r_sramWrData <= wr_data;
                     r_sramWe     <= ~data_mask;
                     r_nextAddr   <= addr + AddrOne;
                     r_state      <= WRITE;
                  end else begin
                     // Minimum latency needs the first SRAM address on the accept edge itself
                     if (AddrFirst == 8'd0) begin
                        r_sramAddr <= addr;
                        r_nextAddr <= addr + AddrOne;
                     end else begin
                        r_nextAddr <= addr;
                     end
                     r_state <= READ_WAIT;
                  end
               end
            end
            WRITE: begin
               if (r_cnt == BurstLen) begin
                  r_sramWe <= 8'd0;
                  r_busy   <= 1'b0;
                  r_cnt    <= 8'd0;
                  r_state  <= IDLE;
               end else begin
                  r_sramAddr   <= r_nextAddr;
                  r_nextAddr   <= r_nextAddr + AddrOne;
                  r_sramWrData <= wr_data;
                  r_sramWe     <= ~data_mask;
                  r_cnt        <= r_cnt + 8'd1;
               end
            end
            READ_WAIT, READ_BURST: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_addrIssue) begin
                  r_sramAddr <= r_nextAddr;
                  r_nextAddr <= r_nextAddr + AddrOne;
               end
               if (r_cnt == DataFirst - 8'd1) begin
                  r_state <= READ_BURST;
               end
               // SRAM data lags its address by one edge, so capture runs two edges behind issue
               if (w_dataCapture) begin
                  r_rdData  <= sram_rd_data;
                  r_rdValid <= 1'b1;
               end
               if (r_cnt == DataStop) begin
                  r_rdValid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_cnt     <= 8'd0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd_data       = r_rdData;
   assign rd_data_valid = r_rdValid;
   assign init_calib    = r_initCalib;
   assign busy          = r_busy;
   assign sram_addr     = r_sramAddr;
   assign sram_wr_data  = r_sramWrData;
   assign sram_we       = r_sramWe;

endmodule

// File: tb/tb_burst_sram_responder.sv
// Scoreboard bench for burst_sram_responder: a byte-enabled SRAM model sits on the SRAM port,
// a word-array reference model predicts read beats, and a monitor checks every valid beat.
module tb_burst_sram_responder;

   localparam int AW   = 10;
   localparam int N    = 4;
   localparam int C    = 6;
   localparam int INIT = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd;
   logic          cmd_en;
   logic [AW-1:0] addr;
   logic [63:0]   wr_data;
   logic [7:0]    data_mask;
   logic [63:0]   rd_data;
   logic          rd_data_valid;
   logic          init_calib;
   logic          busy;
   logic [AW-1:0] sram_addr;
   logic [63:0]   sram_wr_data;
   logic [7:0]    sram_we;
   logic [63:0]   sram_rd_data;

   typedef struct {
      logic [63:0] data;
      longint      cyc;
   } exp_t;

   exp_t        expQ[$];
   logic [63:0] refMem  [DEPTH];
   logic [63:0] sramMem [DEPTH];
   logic [63:0] beatBuf [N];
   longint      cycle = 0;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] lastBeat;
   bit          haveLast = 0;

   burst_sram_responder #(
      .AddressBitWidth(AW),
      .BurstDataCount(N),
      .CyclesBeforeDataValid(C),
      .InitCycles(INIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd(cmd),
      .cmd_en(cmd_en),
      .addr(addr),
      .wr_data(wr_data),
      .data_mask(data_mask),
      .rd_data(rd_data),
      .rd_data_valid(rd_data_valid),
      .init_calib(init_calib),
      .busy(busy),
      .sram_addr(sram_addr),
      .sram_wr_data(sram_wr_data),
      .sram_we(sram_we),
      .sram_rd_data(sram_rd_data)
   );

   always #5 clk = ~clk;

   // Cycle number of the most recent rising edge, read at falling edges
   always @(posedge clk) cycle <= cycle + 1;

   // Synchronous SRAM with byte write enables and one-cycle read latency
   always @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (sram_we[b]) sramMem[sram_addr][8*b +: 8] <= sram_wr_data[8*b +: 8];
      end
      sram_rd_data <= sramMem[sram_addr];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Every valid beat must match the oldest outstanding prediction, on its predicted cycle
   always @(negedge clk) begin
      if (rst) begin
         haveLast = 0;
      end else if (rd_data_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got rd_data_valid=1 rd_data=%h, expected no beat (cycle %0d)", rd_data, cycle);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rd_data", rd_data, e.data);
            checkOutput("rd_cycle", 64'(cycle), 64'(e.cyc));
         end
         lastBeat = rd_data;
         haveLast = 1;
      end else if (haveLast) begin
         checkOutput("rd_hold", rd_data, lastBeat);
      end
   end

   // Called at a falling edge; returns at the falling edge of the first busy=0 cycle after the burst
   task automatic applyStimulus(input bit isWrite, input logic [AW-1:0] a, input logic [7:0] mask, input bit spurious);
      int     waitN;
      longint t;
      waitN = 0;
      while (busy && waitN < 200) begin
         @(negedge clk);
         waitN++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got busy=1 after 200 cycles, expected busy=0");
         return;
      end
      cmd       = isWrite;
      cmd_en    = 1'b1;
      addr      = a;
      wr_data   = beatBuf[0];
      data_mask = mask;
      @(negedge clk);
      t = cycle;
      cmd_en = 1'b0;
      if (isWrite) begin
         for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 8; b++) begin
               if (!mask[b]) refMem[(int'(a) + i) % DEPTH][8*b +: 8] = beatBuf[i][8*b +: 8];
            end
         end
         for (int i = 1; i < N; i++) begin
            wr_data = beatBuf[i];
            checkOutput("write_busy", 64'(busy), 64'd1);
            @(negedge clk);
         end
         checkOutput("write_busy", 64'(busy), 64'd1);
         @(negedge clk);
         checkOutput("write_busy_clear", 64'(busy), 64'd0);
      end else begin
         for (int i = 0; i < N; i++) begin
            exp_t e;
            e.data = refMem[(int'(a) + i) % DEPTH];
            e.cyc  = t + C + i;
            expQ.push_back(e);
         end
         while (cycle < t + C + N) begin
            checkOutput("read_busy", 64'(busy), 64'd1);
            if (spurious) begin
               cmd       = 1'b1;
               cmd_en    = 1'b1;
               addr      = 10'h100;
               wr_data   = 64'hDEAD;
               data_mask = 8'h00;
            end
            @(negedge clk);
         end
         cmd_en = 1'b0;
         checkOutput("read_busy_clear", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: got no finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int bad;
      int w;
      rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = 64'd0; data_mask = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         sramMem[i] = 64'd0;
         refMem[i]  = 64'd0;
      end
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd1);
      checkOutput("reset_init_calib", 64'(init_calib), 64'd0);
      checkOutput("reset_rd_valid", 64'(rd_data_valid), 64'd0);
      checkOutput("reset_rd_data", rd_data, 64'd0);
      checkOutput("reset_sram_we", 64'(sram_we), 64'd0);
      checkOutput("reset_sram_addr", 64'(sram_addr), 64'd0);
      checkOutput("reset_sram_wr_data", sram_wr_data, 64'd0);
      #2 rst = 1'b0;
      for (int i = 0; i < INIT - 1; i++) begin
         @(negedge clk);
         checkOutput("init_calib_low", 64'(init_calib), 64'd0);
         checkOutput("init_busy", 64'(busy), 64'd1);
         checkOutput("init_sram_we", 64'(sram_we), 64'd0);
      end
      @(negedge clk);
      checkOutput("init_calib_high", 64'(init_calib), 64'd1);
      checkOutput("init_busy_low", 64'(busy), 64'd0);

      // Basic write then read
      beatBuf[0] = 64'h1111_1111_1111_1111; beatBuf[1] = 64'h2222_2222_2222_2222;
      beatBuf[2] = 64'h3333_3333_3333_3333; beatBuf[3] = 64'h4444_4444_4444_4444;
      applyStimulus(1'b1, 10'h010, 8'h00, 1'b0);
      applyStimulus(1'b0, 10'h010, 8'h00, 1'b0);

      // Byte mask over a preloaded word
      for (int i = 0; i < N; i++) beatBuf[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      applyStimulus(1'b1, 10'h020, 8'h00, 1'b0);
      for (int i = 0; i < N; i++) beatBuf[i] = 64'd0;
      applyStimulus(1'b1, 10'h020, 8'h0F, 1'b0);
      checkOutput("mask_word", sramMem[10'h020], 64'h0000_0000_FFFF_FFFF);
      applyStimulus(1'b0, 10'h020, 8'h00, 1'b0);

      // Wrap at the top of memory
      beatBuf[0] = 64'hAAAA_0000_0000_000A; beatBuf[1] = 64'hBBBB_0000_0000_000B;
      beatBuf[2] = 64'hCCCC_0000_0000_000C; beatBuf[3] = 64'hDDDD_0000_0000_000D;
      applyStimulus(1'b1, 10'h3FE, 8'h00, 1'b0);
      checkOutput("wrap_3FE", sramMem[10'h3FE], 64'hAAAA_0000_0000_000A);
      checkOutput("wrap_3FF", sramMem[10'h3FF], 64'hBBBB_0000_0000_000B);
      checkOutput("wrap_000", sramMem[10'h000], 64'hCCCC_0000_0000_000C);
      checkOutput("wrap_001", sramMem[10'h001], 64'hDDDD_0000_0000_000D);
      applyStimulus(1'b0, 10'h3FE, 8'h00, 1'b0);

      // Ignored command during a read, then a back-to-back read
      applyStimulus(1'b0, 10'h010, 8'h00, 1'b1);
      applyStimulus(1'b0, 10'h3FE, 8'h00, 1'b0);
      checkOutput("ignored_write", sramMem[10'h100], 64'd0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         bit            isW;
         logic [AW-1:0] a;
         logic [7:0]    m;
         isW = ($urandom_range(0, 1) == 1);
         a   = ($urandom_range(0, 4) == 0) ? AW'(10'h3FC + $urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
         m   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         for (int i = 0; i < N; i++) beatBuf[i] = {$urandom, $urandom};
         applyStimulus(isW, a, m, ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset during the read latency window
      cmd = 1'b0; addr = 10'h010; cmd_en = 1'b1;
      @(negedge clk);
      cmd_en = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("midreset_rd_valid", 64'(rd_data_valid), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd1);
      checkOutput("midreset_init_calib", 64'(init_calib), 64'd0);
      checkOutput("midreset_rd_data", rd_data, 64'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      w = 0;
      while (!init_calib && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkOutput("reinit_calib", 64'(init_calib), 64'd1);
      applyStimulus(1'b0, 10'h010, 8'h00, 1'b0);
      applyStimulus(1'b0, 10'h020, 8'h00, 1'b0);

      repeat (5) @(negedge clk);
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sramMem[i] !== refMem[i]) bad++;
      end
      checkOutput("mem_compare", 64'(bad), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
